dht11_sampler: RTL

DHT11_SAMPLER -- requirements
Module: dht11_sampler

---
 rtl/dht11_pkg.sv | 23 ++
 rtl/dht11_sampler_bin2bcd.sv | 66 ++++++
 rtl/dht11_sampler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 sampler and the DHT11 reader:
// state encodings and the default timing constants at a 50 MHz clock.
package dht11_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TRIGGER   = 4'd1,
        ST_WAIT_RESP = 4'd2,
        ST_BACKOFF   = 4'd3,
        ST_CONVERT   = 4'd4,
        ST_DONE      = 4'd5,
        ST_FAIL      = 4'd6
    } state_e;

    localparam int CLK_HZ            = 50_000_000;
    localparam int DEF_SAMPLE_PERIOD = 100_000_000;
    localparam int DEF_RESP_TIMEOUT  = 2_500_000;
    localparam int DEF_RETRY_GAP     = 50_000_000;
    localparam int DEF_MAX_RETRY     = 3;

    localparam int BCD_ITERS = 8;

endpackage

// File: rtl/dht11_sampler_bin2bcd.sv
// 8-bit sequential double-dabble: one shift-add-3 iteration per cycle,
// done pulses once after the eighth iteration and bcd_o then holds the result.
module bin2bcd_seq
    import dht11_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  bin_i,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    logic [19:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5) begin
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (start_i) begin
            shift_d = {12'd0, bin_i};
            cnt_d   = 4'd0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            shift_d = dabble_step(shift_q);
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'(BCD_ITERS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = shift_q[19:8];

endmodule

// File: rtl/dht11_sampler.sv
// Periodic / on-demand DHT11 measurement scheduler with retry, timeout and
// BCD conversion of the integer humidity and temperature bytes.
module dht11_sampler
    import dht11_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int RESP_TIMEOUT  = DEF_RESP_TIMEOUT,
    parameter int RETRY_GAP     = DEF_RETRY_GAP,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        measure,
    output logic        sensor_start,
    input  logic        sensor_pronto,
    input  logic        sensor_error,
    input  logic [15:0] sensor_umidade,
    input  logic [15:0] sensor_temperatura,
    output logic [7:0]  umid_int,
    output logic [7:0]  temp_int,
    output logic [11:0] umid_bcd,
    output logic [11:0] temp_bcd,
    output logic        valid,
    output logic        new_sample,
    output logic        fail,
    output logic [3:0]  db_estado
);

    state_e      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] tmr_q, tmr_d;
    logic [7:0]  attempt_q, attempt_d;
    logic        pronto_prev_q, error_prev_q;
    logic [7:0]  umid_lat_q, umid_lat_d, temp_lat_q, temp_lat_d;
    logic [7:0]  umid_int_q, umid_int_d, temp_int_q, temp_int_d;
    logic [11:0] umid_bcd_q, umid_bcd_d, temp_bcd_q, temp_bcd_d;
    logic        valid_q, valid_d, new_sample_q, new_sample_d, fail_q, fail_d;

    logic        pronto_rise, error_rise, conv_start;
    logic        umid_done, temp_done;
    logic [11:0] umid_conv, temp_conv;

    assign pronto_rise = sensor_pronto & ~pronto_prev_q;
    assign error_rise  = sensor_error  & ~error_prev_q;

    // Converters load straight from the sensor bytes on the same edge that latches them.
    bin2bcd_seq u_bcd_umid (
        .clock   (clock),
        .reset   (reset),
        .start_i (conv_start),
        .bin_i   (sensor_umidade[15:8]),
        .done_o  (umid_done),
        .bcd_o   (umid_conv)
    );

    bin2bcd_seq u_bcd_temp (
        .clock   (clock),
        .reset   (reset),
        .start_i (conv_start),
        .bin_i   (sensor_temperatura[15:8]),
        .done_o  (temp_done),
        .bcd_o   (temp_conv)
    );

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        tmr_d        = tmr_q;
        attempt_d    = attempt_q;
        umid_lat_d   = umid_lat_q;
        temp_lat_d   = temp_lat_q;
        umid_int_d   = umid_int_q;
        temp_int_d   = temp_int_q;
        umid_bcd_d   = umid_bcd_q;
        temp_bcd_d   = temp_bcd_q;
        valid_d      = valid_q;
        fail_d       = fail_q;
        new_sample_d = 1'b0;
        conv_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (measure || (enable && period_q == 32'(SAMPLE_PERIOD - 1))) begin
                    state_d   = ST_TRIGGER;
                    period_d  = '0;
                    attempt_d = '0;
                end else if (enable) begin
                    period_d = period_q + 32'd1;
                end else begin
                    period_d = '0;
                end
            end
            ST_TRIGGER: begin
                tmr_d   = '0;
                state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                // Error wins over a simultaneous pronto edge.
                if (error_rise || tmr_q == 32'(RESP_TIMEOUT - 1)) begin
                    attempt_d = attempt_q + 8'd1;
                    tmr_d     = '0;
                    state_d   = (attempt_d < 8'(MAX_RETRY)) ? ST_BACKOFF : ST_FAIL;
                end else if (pronto_rise) begin
                    umid_lat_d = sensor_umidade[15:8];
                    temp_lat_d = sensor_temperatura[15:8];
                    conv_start = 1'b1;
                    state_d    = ST_CONVERT;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            ST_BACKOFF: begin
                if (tmr_q == 32'(RETRY_GAP - 1)) begin
                    tmr_d   = '0;
                    state_d = ST_TRIGGER;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            ST_CONVERT: begin
                if (umid_done && temp_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                umid_int_d   = umid_lat_q;
                temp_int_d   = temp_lat_q;
                umid_bcd_d   = umid_conv;
                temp_bcd_d   = temp_conv;
                valid_d      = 1'b1;
                fail_d       = 1'b0;
                new_sample_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_FAIL: begin
                fail_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            period_q      <= '0;
            tmr_q         <= '0;
            attempt_q     <= '0;
            pronto_prev_q <= 1'b0;
            error_prev_q  <= 1'b0;
            umid_lat_q    <= '0;
            temp_lat_q    <= '0;
            umid_int_q    <= '0;
            temp_int_q    <= '0;
            umid_bcd_q    <= '0;
            temp_bcd_q    <= '0;
            valid_q       <= 1'b0;
            new_sample_q  <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            tmr_q         <= tmr_d;
            attempt_q     <= attempt_d;
            pronto_prev_q <= sensor_pronto;
            error_prev_q  <= sensor_error;
            umid_lat_q    <= umid_lat_d;
            temp_lat_q    <= temp_lat_d;
            umid_int_q    <= umid_int_d;
            temp_int_q    <= temp_int_d;
            umid_bcd_q    <= umid_bcd_d;
            temp_bcd_q    <= temp_bcd_d;
            valid_q       <= valid_d;
            new_sample_q  <= new_sample_d;
            fail_q        <= fail_d;
        end
    end

    assign sensor_start = (state_q == ST_TRIGGER);
    assign umid_int     = umid_int_q;
    assign temp_int     = temp_int_q;
    assign umid_bcd     = umid_bcd_q;
    assign temp_bcd     = temp_bcd_q;
    assign valid        = valid_q;
    assign new_sample   = new_sample_q;
    assign fail         = fail_q;
    assign db_estado    = state_q;

endmodule
